sprite_attr_commit: RTL and testbench

Double-buffered sprite attribute table controller, placed between the CPU register interface and `sprite_engine`'s attribute write port. The CPU writes sprite attributes into a shadow table at any time. On request, the block copies only the modified (dirty) entries into the engine's attribute RAM at the start of vertical blanking. This makes every frame render from a coherent attribute set and prevents tearing.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_shadow_table.sv | 44 ++++
 rtl/sprite_attr_commit.sv | 126 ++++++++++++
 tb/tb_sprite_attr_commit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite attribute commit path.
// Attribute word layout, table geometry and commit FSM states.
package sprite_pkg;

    localparam int NUM_SPRITE  = 32;
    localparam int VBLANK_LINE = 480;

    typedef struct packed {
        logic       enable;
        logic       flip;
        logic [2:0] rsvd;
        logic [8:0] row;
        logic [9:0] col;
        logic [7:0] frame_id;
    } sprite_attr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COPY
    } commit_state_t;

endpackage

// File: rtl/sprite_shadow_table.sv
// Shadow sprite attribute table with per-entry dirty bits.
// CPU write port, one indexed read port, clear-dirty strobe.
module sprite_shadow_table
    import sprite_pkg::sprite_attr_t;
#(
    parameter int NUM_SPRITE = 32,
    parameter int IW         = $clog2(NUM_SPRITE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [IW-1:0] wr_idx,
    input  sprite_attr_t wr_data,
    input  logic [IW-1:0] rd_idx,
    output sprite_attr_t rd_data,
    output logic         rd_dirty,
    input  logic         clr_dirty
);

    sprite_attr_t            mem [NUM_SPRITE];
    logic [NUM_SPRITE-1:0]   dirty;

    assign rd_data  = mem[rd_idx];
    assign rd_dirty = dirty[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITE; i++) begin
                mem[i] <= '0;
            end
            dirty <= '0;
        end else begin
            if (clr_dirty) begin
                dirty[rd_idx] <= 1'b0;
            end
            // Later assignment wins: a CPU write keeps the entry dirty.
            if (wr_en) begin
                mem[wr_idx]   <= wr_data;
                dirty[wr_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_attr_commit.sv
// Commits dirty shadow sprite attributes to the engine RAM
// at the start of vertical blanking.
module sprite_attr_commit
    import sprite_pkg::sprite_attr_t;
    import sprite_pkg::commit_state_t;
    import sprite_pkg::ST_IDLE;
    import sprite_pkg::ST_ARMED;
    import sprite_pkg::ST_COPY;
#(
    parameter int   NUM_SPRITE  = sprite_pkg::NUM_SPRITE,
    parameter int   VBLANK_LINE = sprite_pkg::VBLANK_LINE,
    localparam int  IW          = $clog2(NUM_SPRITE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    vcount,
    input  logic          cpu_wr_en,
    input  logic [IW-1:0] cpu_wr_idx,
    input  logic [31:0]   cpu_wr_data,
    input  logic          commit,
    output logic          spr_wr_en,
    output logic [IW-1:0] spr_wr_idx,
    output logic [31:0]   spr_wr_data,
    output logic          commit_pending,
    output logic          busy,
    output logic          commit_done
);

    commit_state_t state;
    logic [IW-1:0] ptr;
    logic          rearm;
    logic [9:0]    prev_vcount;
    logic          vblank_start;
    logic          last;
    sprite_attr_t  rd_data;
    logic          rd_dirty;
    logic          clr_dirty;

    assign vblank_start = (vcount == 10'(VBLANK_LINE))
                       && (prev_vcount != 10'(VBLANK_LINE));
    assign last      = (ptr == IW'(NUM_SPRITE - 1));
    assign clr_dirty = (state == ST_COPY) && rd_dirty;

    sprite_shadow_table #(
        .NUM_SPRITE (NUM_SPRITE),
        .IW         (IW)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (cpu_wr_en),
        .wr_idx    (cpu_wr_idx),
        .wr_data   (cpu_wr_data),
        .rd_idx    (ptr),
        .rd_data   (rd_data),
        .rd_dirty  (rd_dirty),
        .clr_dirty (clr_dirty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            rearm          <= 1'b0;
            prev_vcount    <= '0;
            spr_wr_en      <= 1'b0;
            spr_wr_idx     <= '0;
            spr_wr_data    <= '0;
            commit_pending <= 1'b0;
            busy           <= 1'b0;
            commit_done    <= 1'b0;
        end else begin
            prev_vcount <= vcount;
            spr_wr_en   <= 1'b0;
            commit_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (commit && vblank_start) begin
                        state <= ST_COPY;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else if (commit) begin
                        state          <= ST_ARMED;
                        commit_pending <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    busy <= 1'b0;
                    if (vblank_start) begin
                        state          <= ST_COPY;
                        ptr            <= '0;
                        commit_pending <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                ST_COPY: begin
                    if (rd_dirty) begin
                        spr_wr_en   <= 1'b1;
                        spr_wr_idx  <= ptr;
                        spr_wr_data <= rd_data;
                    end
                    ptr <= ptr + IW'(1);
                    if (commit) begin
                        rearm <= 1'b1;
                    end
                    // busy stays up through the done cycle.
                    if (last) begin
                        commit_done <= 1'b1;
                        ptr         <= '0;
                        rearm       <= 1'b0;
                        if (rearm || commit) begin
                            state          <= ST_ARMED;
                            commit_pending <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_attr_commit.sv
// Directed bench for sprite_attr_commit with a per-cycle
// reference model and literal pass-level expectations.
module tb_sprite_attr_commit;

    localparam int NS = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    vcount = '0;
    logic          cpu_wr_en = 1'b0;
    logic [IW-1:0] cpu_wr_idx = '0;
    logic [31:0]   cpu_wr_data = '0;
    logic          commit = 1'b0;
    logic          spr_wr_en;
    logic [IW-1:0] spr_wr_idx;
    logic [31:0]   spr_wr_data;
    logic          commit_pending;
    logic          busy;
    logic          commit_done;

    always #5 clk = ~clk;

    sprite_attr_commit #(
        .NUM_SPRITE  (NS),
        .VBLANK_LINE (480)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .vcount         (vcount),
        .cpu_wr_en      (cpu_wr_en),
        .cpu_wr_idx     (cpu_wr_idx),
        .cpu_wr_data    (cpu_wr_data),
        .commit         (commit),
        .spr_wr_en      (spr_wr_en),
        .spr_wr_idx     (spr_wr_idx),
        .spr_wr_data    (spr_wr_data),
        .commit_pending (commit_pending),
        .busy           (busy),
        .commit_done    (commit_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: shadow contents, dirty set, pass position.
    logic [31:0] m_shadow [NS];
    bit          m_dirty  [NS];
    int          m_pos   = -1;
    bit          m_armed = 1'b0;
    bit          m_rearm = 1'b0;
    logic [9:0]  m_prev  = '0;
    logic        e_en = 1'b0, e_pend = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [IW-1:0] e_idx = '0;
    logic [31:0] e_data = '0;

    task automatic model_step();
        bit vbs;
        bit fin;
        vbs    = (vcount == 10'd480) && (m_prev != 10'd480);
        fin    = 1'b0;
        e_en   = 1'b0;
        e_done = 1'b0;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_shadow[i] = '0;
                m_dirty[i]  = 1'b0;
            end
            m_pos   = -1;
            m_armed = 1'b0;
            m_rearm = 1'b0;
            m_prev  = '0;
            e_idx   = '0;
            e_data  = '0;
            e_pend  = 1'b0;
            e_busy  = 1'b0;
        end else begin
            if (m_pos >= 0) begin
                if (m_dirty[m_pos]) begin
                    e_en   = 1'b1;
                    e_idx  = IW'(m_pos);
                    e_data = m_shadow[m_pos];
                    m_dirty[m_pos] = 1'b0;
                end
                if (commit) m_rearm = 1'b1;
                if (m_pos == NS - 1) begin
                    e_done  = 1'b1;
                    fin     = 1'b1;
                    m_pos   = -1;
                    m_armed = m_rearm;
                    m_rearm = 1'b0;
                end else begin
                    m_pos++;
                end
            end else if (m_armed || commit) begin
                if (vbs) begin
                    m_armed = 1'b0;
                    m_pos   = 0;
                end else begin
                    m_armed = 1'b1;
                end
            end
            if (cpu_wr_en) begin
                m_shadow[cpu_wr_idx] = cpu_wr_data;
                m_dirty[cpu_wr_idx]  = 1'b1;
            end
            e_busy = (m_pos >= 0) || fin;
            e_pend = m_armed;
            m_prev = vcount;
        end
    endtask

    typedef struct {
        int          rel;
        int          idx;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  vbs_at = 0;
    int  busy_cnt = 0;
    int  done_cnt = 0;
    int  done_rel = -1;

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("spr_wr_en", 32'(spr_wr_en), 32'(e_en));
        chk("spr_wr_idx", 32'(spr_wr_idx), 32'(e_idx));
        chk("spr_wr_data", spr_wr_data, e_data);
        chk("commit_pending", 32'(commit_pending), 32'(e_pend));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("commit_done", 32'(commit_done), 32'(e_done));
        if (spr_wr_en) begin
            wq.push_back('{rel: cyc - vbs_at + 1,
                           idx: int'(spr_wr_idx),
                           data: spr_wr_data});
        end
        if (busy) busy_cnt++;
        if (commit_done) begin
            done_cnt++;
            done_rel = cyc - vbs_at + 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        cpu_wr_en   = 1'b1;
        cpu_wr_idx  = IW'(idx);
        cpu_wr_data = data;
        tick();
        cpu_wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic clear_log();
        wq.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_rel = -1;
    endtask

    task automatic vblank();
        vcount = 10'd480;
        vbs_at = cyc + 1;
        tick();
        vcount = 10'd481;
    endtask

    task automatic chk_one(input string name, input int rel,
                           input int idx, input logic [31:0] data);
        chk({name, "_count"}, 32'(wq.size()), 32'd1);
        if (wq.size() == 1) begin
            chk({name, "_rel"}, 32'(wq[0].rel), 32'(rel));
            chk({name, "_idx"}, 32'(wq[0].idx), 32'(idx));
            chk({name, "_data"}, wq[0].data, data);
        end
    endtask

    initial begin
        run(2);
        reset = 1'b0;
        chk("rst_wr_en", 32'(spr_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(commit_pending), 32'd0);
        chk("rst_done", 32'(commit_done), 32'd0);

        // Two dirty entries, committed at scanline 100.
        vcount = 10'd100;
        run(2);
        wr(3, 32'h8401_0001);
        wr(17, 32'h8000_0005);
        pulse_commit();
        chk("t1_pending", 32'(commit_pending), 32'd1);
        clear_log();
        vblank();
        run(40);
        chk("t1_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("t1_w0_rel", 32'(wq[0].rel), 32'd5);
            chk("t1_w0_idx", 32'(wq[0].idx), 32'd3);
            chk("t1_w0_data", wq[0].data, 32'h8401_0001);
            chk("t1_w1_rel", 32'(wq[1].rel), 32'd19);
            chk("t1_w1_idx", 32'(wq[1].idx), 32'd17);
            chk("t1_w1_data", wq[1].data, 32'h8000_0005);
        end
        chk("t1_done_rel", 32'(done_rel), 32'd33);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("t1_pending_after", 32'(commit_pending), 32'd0);

        // Nothing dirty: full pass, no engine writes.
        pulse_commit();
        clear_log();
        vblank();
        run(40);
        chk("t2_count", 32'(wq.size()), 32'd0);
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Writes ahead of and behind the copy pointer.
        pulse_commit();
        clear_log();
        vblank();
        run(10);
        wr(20, 32'h8123_4567);
        wr(5, 32'h8000_0505);
        run(40);
        chk_one("t3a", 22, 20, 32'h8123_4567);
        pulse_commit();
        clear_log();
        vblank();
        run(40);
        chk_one("t3b", 7, 5, 32'h8000_0505);

        // Write colliding with the entry being copied.
        wr(8, 32'h1111_1111);
        pulse_commit();
        clear_log();
        vblank();
        run(8);
        wr(8, 32'hAAAA_AAAA);
        run(40);
        chk_one("t4a", 10, 8, 32'h1111_1111);
        pulse_commit();
        clear_log();
        vblank();
        run(40);
        chk_one("t4b", 10, 8, 32'hAAAA_AAAA);

        // Commit during a pass re-arms for the next vblank.
        wr(2, 32'h8000_0002);
        pulse_commit();
        clear_log();
        vblank();
        run(4);
        pulse_commit();
        run(40);
        chk_one("t5a", 4, 2, 32'h8000_0002);
        chk("t5_rearmed", 32'(commit_pending), 32'd1);
        wr(2, 32'h8000_0022);
        clear_log();
        vblank();
        run(40);
        chk_one("t5b", 4, 2, 32'h8000_0022);
        chk("t5b_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5b_pending", 32'(commit_pending), 32'd0);

        // Commit on the vblank_start cycle from idle.
        clear_log();
        commit = 1'b1;
        vcount = 10'd480;
        vbs_at = cyc + 1;
        tick();
        commit = 1'b0;
        vcount = 10'd481;
        chk("t5c_busy", 32'(busy), 32'd1);
        chk("t5c_pending", 32'(commit_pending), 32'd0);
        run(40);
        chk("t5c_done_rel", 32'(done_rel), 32'd33);

        // Reset in the middle of a pass.
        wr(20, 32'h8000_0014);
        pulse_commit();
        clear_log();
        vblank();
        run(12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_wr_en", 32'(spr_wr_en), 32'd0);
        chk("t6_idx", 32'(spr_wr_idx), 32'd0);
        chk("t6_data", spr_wr_data, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pending", 32'(commit_pending), 32'd0);
        chk("t6_done", 32'(commit_done), 32'd0);
        pulse_commit();
        clear_log();
        vblank();
        run(40);
        chk("t6_count", 32'(wq.size()), 32'd0);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
